// File: rtl/wide_add_sequencer_pkg.sv
// Shared constants and state encoding for the wide-word add sequencer.
package wide_add_sequencer_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/wide_add_sequencer_rca.sv
// 16-bit ripple-carry adder slice shared by the sequencer.
module ripple_carry_adder
    import wide_add_sequencer_pkg::*;
(
    input  logic [WORD_W-1:0] A,
    input  logic [WORD_W-1:0] B,
    input  logic              cin,
    output logic [WORD_W-1:0] S,
    output logic              cout
);

    logic c;

    always_comb begin
        c = cin;
        S = '0;
        for (int i = 0; i < WORD_W; i++) begin
            S[i] = A[i] ^ B[i] ^ c;
            c    = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/wide_add_sequencer.sv
// Wide adder built from one 16-bit ripple adder stepped over WORDS slices,
// LSB slice first, with the inter-slice carry held in a flop.
module wide_add_sequencer
    import wide_add_sequencer_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [WORD_W*WORDS-1:0] A,
    input  logic [WORD_W*WORDS-1:0] B,
    input  logic                    cin,
    output logic                    busy,
    output logic                    done,
    output logic [WORD_W*WORDS-1:0] S,
    output logic                    cout,
    output logic                    ovf
);

    localparam int W     = WORD_W * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d;
    logic [W-1:0]     acc_q, acc_d, s_q, s_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [WORD_W-1:0] add_a, add_b, add_s;
    logic              add_co;

    assign add_a = a_q[idx_q*WORD_W +: WORD_W];
    assign add_b = b_q[idx_q*WORD_W +: WORD_W];

    ripple_carry_adder u_rca (
        .A    (add_a),
        .B    (add_b),
        .cin  (carry_q),
        .S    (add_s),
        .cout (add_co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        acc_d   = acc_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d[idx_q*WORD_W +: WORD_W] = add_s;
                carry_d = add_co;
                idx_d   = idx_q + 1'b1;
                // Last slice: publish the full result on the same edge it completes.
                if (idx_q == IDX_W'(WORDS - 1)) begin
                    idx_d   = '0;
                    state_d = DONE;
                    s_d     = acc_d;
                    cout_d  = add_co;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (acc_d[W-1] != a_q[W-1]);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            acc_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign S    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Randomized and directed checks of wide_add_sequencer (WORDS=4 and WORDS=1)
// against a cycle-count model of the request/result behaviour.
module tb_wide_add_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        st [2];
    logic [63:0] ia [2];
    logic [63:0] ib [2];
    logic        ic [2];

    logic [1:0]  busy_o, done_o, co_o, ov_o;
    logic [63:0] s4;
    logic [15:0] s1;

    int n_chk = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    wide_add_sequencer #(.WORDS(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .A(ia[0]), .B(ib[0]), .cin(ic[0]),
        .busy(busy_o[0]), .done(done_o[0]), .S(s4), .cout(co_o[0]), .ovf(ov_o[0])
    );

    wide_add_sequencer #(.WORDS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .A(ia[1][15:0]), .B(ib[1][15:0]), .cin(ic[1]),
        .busy(busy_o[1]), .done(done_o[1]), .S(s1), .cout(co_o[1]), .ovf(ov_o[1])
    );

    function automatic int wd(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: -1 when idle, otherwise cycles elapsed since the accepting edge.
    int          m_cnt [2] = '{-1, -1};
    logic [63:0] m_a [2], m_b [2];
    logic        m_c [2];
    logic [63:0] e_s [2] = '{64'd0, 64'd0};
    logic        e_co [2] = '{1'b0, 1'b0};
    logic        e_ov [2] = '{1'b0, 1'b0};
    logic [64:0] full;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_cnt[d] = -1;
                e_s[d]   = '0;
                e_co[d]  = 1'b0;
                e_ov[d]  = 1'b0;
            end else if (m_cnt[d] < 0) begin
                if (st[d]) begin
                    m_a[d]   = (d == 0) ? ia[d] : {48'd0, ia[d][15:0]};
                    m_b[d]   = (d == 0) ? ib[d] : {48'd0, ib[d][15:0]};
                    m_c[d]   = ic[d];
                    m_cnt[d] = 0;
                end
            end else if (m_cnt[d] == wd(d)) begin
                m_cnt[d] = -1;
            end else begin
                m_cnt[d]++;
                if (m_cnt[d] == wd(d)) begin
                    full = {1'b0, m_a[d]} + {1'b0, m_b[d]} + 65'(m_c[d]);
                    if (d == 0) begin
                        e_s[d]  = full[63:0];
                        e_co[d] = full[64];
                        e_ov[d] = (m_a[d][63] == m_b[d][63]) && (full[63] != m_a[d][63]);
                    end else begin
                        e_s[d]  = {48'd0, full[15:0]};
                        e_co[d] = full[16];
                        e_ov[d] = (m_a[d][15] == m_b[d][15]) && (full[15] != m_a[d][15]);
                    end
                end
            end
        end
    end

    logic [63:0] sa;
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                sa = (d == 0) ? s4 : {48'd0, s1};
                chk(d ? "w1_busy" : "w4_busy", 64'(busy_o[d]), 64'(m_cnt[d] >= 0));
                chk(d ? "w1_done" : "w4_done", 64'(done_o[d]), 64'(m_cnt[d] == wd(d)));
                chk(d ? "w1_S" : "w4_S", sa, e_s[d]);
                chk(d ? "w1_cout" : "w4_cout", 64'(co_o[d]), 64'(e_co[d]));
                chk(d ? "w1_ovf" : "w4_ovf", 64'(ov_o[d]), 64'(e_ov[d]));
            end
        end
    end

    function automatic logic [63:0] rnd64();
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            case ($urandom % 4)
                0:       r[i*16 +: 16] = 16'h0000;
                1:       r[i*16 +: 16] = 16'hFFFF;
                default: r[i*16 +: 16] = 16'($urandom);
            endcase
        end
        return r;
    endfunction

    // Single request with literal expectations, including accept-to-done latency.
    task automatic op(input int d, input logic [63:0] a, input logic [63:0] b, input logic c,
                      input logic [63:0] xs, input logic xco, input logic xov, input string nm);
        int k;
        @(negedge clk);
        st[d] = 1'b1; ia[d] = a; ib[d] = b; ic[d] = c;
        @(negedge clk);
        st[d] = 1'b0;
        k = 0;
        while (!done_o[d] && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_lat"}, 64'(k), 64'(wd(d)));
        chk({nm, "_S"}, (d == 0) ? s4 : {48'd0, s1}, xs);
        chk({nm, "_cout"}, 64'(co_o[d]), 64'(xco));
        chk({nm, "_ovf"}, 64'(ov_o[d]), 64'(xov));
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int ndone, t_first, t_prev, gap_bad, late_done;

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            st[d] = 1'b0; ia[d] = '0; ib[d] = '0; ic[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_S4", s4, 64'd0);
        chk("rst_S1", 64'(s1), 64'd0);
        chk("rst_cout_ovf", 64'({co_o, ov_o}), 64'd0);
        chk_en = 1'b1;
        rst_n  = 1'b1;

        op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0, "ones_p1");
        op(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, "sovf");
        op(0, 64'h0000_0000_0000_FFFF, 64'h1, 1'b1, 64'h0000_0000_0001_0001, 1'b0, 1'b0, "carry");
        op(1, 64'h8000, 64'h8000, 1'b0, 64'd0, 1'b1, 1'b1, "w1");

        // Held start with operands changing every cycle.
        @(negedge clk);
        st[0] = 1'b1; ia[0] = rnd64(); ib[0] = rnd64(); ic[0] = 1'($urandom);
        ndone = 0; t_first = -1; t_prev = -1; gap_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_o[0]) begin
                if (t_prev >= 0 && i - t_prev != 6) gap_bad++;
                if (t_first < 0) t_first = i;
                t_prev = i;
                ndone++;
            end
            ia[0] = rnd64(); ib[0] = rnd64(); ic[0] = 1'($urandom);
        end
        st[0] = 1'b0;
        chk("held_ndone", 64'(ndone), 64'd3);
        chk("held_first", 64'(t_first), 64'd4);
        chk("held_gap", 64'(gap_bad), 64'd0);
        repeat (10) @(negedge clk);

        // Reset two cycles into RUN.
        st[0] = 1'b1; ia[0] = 64'hDEAD_BEEF_1234_5678; ib[0] = 64'h1111_2222_3333_4444; ic[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst_busy", 64'(busy_o[0]), 64'd0);
        chk("mrst_done", 64'(done_o[0]), 64'd0);
        chk("mrst_S", s4, 64'd0);
        chk("mrst_cov", 64'({co_o[0], ov_o[0]}), 64'd0);
        late_done = 0;
        repeat (8) begin
            @(negedge clk);
            if (done_o[0]) late_done++;
        end
        chk("mrst_nodone", 64'(late_done), 64'd0);
        op(0, 64'h1234, 64'h0001, 1'b0, 64'h1235, 1'b0, 1'b0, "post_rst");

        // Randomized traffic on both instances, with occasional resets.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            rst_n = (($urandom % 100) != 0);
            for (int d = 0; d < 2; d++) begin
                st[d] = (($urandom % 3) != 0);
                ia[d] = rnd64();
                ib[d] = rnd64();
                ic[d] = 1'($urandom);
            end
        end
        rst_n = 1'b1;
        st[0] = 1'b0;
        st[1] = 1'b0;
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
